// File: rtl/bin_video_pkg.sv
// Shared encodings and default 1280x720 raster timing for the binary video source.
package bin_video_pkg;

   localparam logic [1:0] PAT_ONES   = 2'd0;
   localparam logic [1:0] PAT_CHECK  = 2'd1;
   localparam logic [1:0] PAT_STRIPE = 2'd2;
   localparam logic [1:0] PAT_DOTS   = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [10:0] DEF_H_SYNC  = 11'd40;
   localparam logic [10:0] DEF_H_BACK  = 11'd220;
   localparam logic [10:0] DEF_H_DISP  = 11'd1280;
   localparam logic [10:0] DEF_H_FRONT = 11'd110;
   localparam logic [10:0] DEF_H_TOTAL = 11'd1650;
   localparam logic [10:0] DEF_V_SYNC  = 11'd5;
   localparam logic [10:0] DEF_V_BACK  = 11'd20;
   localparam logic [10:0] DEF_V_DISP  = 11'd720;
   localparam logic [10:0] DEF_V_FRONT = 11'd5;
   localparam logic [10:0] DEF_V_TOTAL = 11'd750;

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters with sync, active-area flag, active-relative x/y and last-clock-of-frame strobe.
module video_timing_gen #(
   parameter logic [10:0] H_SYNC  = 11'd40,
   parameter logic [10:0] H_BACK  = 11'd220,
   parameter logic [10:0] H_DISP  = 11'd1280,
   parameter logic [10:0] H_TOTAL = 11'd1650,
   parameter logic [10:0] V_SYNC  = 11'd5,
   parameter logic [10:0] V_BACK  = 11'd20,
   parameter logic [10:0] V_DISP  = 11'd720,
   parameter logic [10:0] V_TOTAL = 11'd750
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adv_i,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        active_o,
   output logic [10:0] x_o,
   output logic [10:0] y_o,
   output logic        last_o
);

   localparam logic [10:0] H_ACT0 = H_SYNC + H_BACK;
   localparam logic [10:0] H_ACT1 = H_ACT0 + H_DISP;
   localparam logic [10:0] V_ACT0 = V_SYNC + V_BACK;
   localparam logic [10:0] V_ACT1 = V_ACT0 + V_DISP;

   logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        h_last, v_last;

   assign h_last = (hcnt_q == H_TOTAL - 11'd1);
   assign v_last = (vcnt_q == V_TOTAL - 11'd1);

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (adv_i) begin
         if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + 11'd1;
         end else begin
            hcnt_d = hcnt_q + 11'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign hsync_o  = (hcnt_q < H_SYNC);
   assign vsync_o  = (vcnt_q < V_SYNC);
   assign active_o = (hcnt_q >= H_ACT0) && (hcnt_q < H_ACT1) &&
                     (vcnt_q >= V_ACT0) && (vcnt_q < V_ACT1);
   assign x_o      = hcnt_q - H_ACT0;
   assign y_o      = vcnt_q - V_ACT0;
   assign last_o   = h_last && v_last;

endmodule

// File: rtl/bin_video_source.sv
// Binary test-pattern video source with whole-frame enable handling.
// Optional LFSR pixel noise is built when BIN_SRC_NOISE_EN is defined.
module bin_video_source
   import bin_video_pkg::*;
#(
   parameter logic [10:0] H_SYNC     = DEF_H_SYNC,
   parameter logic [10:0] H_BACK     = DEF_H_BACK,
   parameter logic [10:0] H_DISP     = DEF_H_DISP,
   parameter logic [10:0] H_FRONT    = DEF_H_FRONT,
   parameter logic [10:0] H_TOTAL    = DEF_H_TOTAL,
   parameter logic [10:0] V_SYNC     = DEF_V_SYNC,
   parameter logic [10:0] V_BACK     = DEF_V_BACK,
   parameter logic [10:0] V_DISP     = DEF_V_DISP,
   parameter logic [10:0] V_FRONT    = DEF_V_FRONT,
   parameter logic [10:0] V_TOTAL    = DEF_V_TOTAL,
   parameter int          CELL_LOG2  = 3,
   parameter logic [15:0] NOISE_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [7:0]  noise_density,
   output logic        post_img_vsync,
   output logic        post_img_hsync,
   output logic        post_img_valid,
   output logic        post_img_data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   logic [1:0]  state_q, state_d, sel_q;
   logic        go, wrap, start, pat, pix;
   logic        tg_hs, tg_vs, tg_act, tg_last;
   logic [10:0] x, y;
   logic        vsync_q, hsync_q, valid_q, data_q, done_q;
   logic [15:0] fcnt_q;
   logic        unused_ok;

   video_timing_gen #(
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_TOTAL(H_TOTAL),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_TOTAL(V_TOTAL)
   ) u_tg (
      .clk(clk), .rst_n(rst_n), .adv_i(go),
      .hsync_o(tg_hs), .vsync_o(tg_vs), .active_o(tg_act),
      .x_o(x), .y_o(y), .last_o(tg_last)
   );

   // Leaving IDLE consumes pixel (0,0) on the same edge, so output starts one clock after enable.
   assign go    = (state_q != ST_IDLE) || enable;
   assign wrap  = go && tg_last;
   assign start = ((state_q == ST_IDLE) && enable) || wrap;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = tg_last ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: if (tg_last) state_d = enable ? ST_RUN : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pat = 1'b1;
      case (sel_q)
         PAT_ONES:   pat = 1'b1;
         PAT_CHECK:  pat = x[CELL_LOG2] ^ y[CELL_LOG2];
         PAT_STRIPE: pat = x[CELL_LOG2];
         PAT_DOTS:   pat = (x[CELL_LOG2-1:0] == '0) && (y[CELL_LOG2-1:0] == '0);
      endcase
   end

`ifdef BIN_SRC_NOISE_EN
   logic [15:0] lfsr_q;
   logic [7:0]  dens_q;
   logic        fb;

   assign fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign pix = pat ^ (lfsr_q[7:0] < dens_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= NOISE_SEED;
         dens_q <= '0;
      end else begin
         if (go && tg_act) lfsr_q <= {lfsr_q[14:0], fb};
         if (start) dens_q <= noise_density;
      end
   end

   assign unused_ok = ^{x, y, H_FRONT, V_FRONT};
`else
   assign pix       = pat;
   assign unused_ok = ^{x, y, H_FRONT, V_FRONT, noise_density, NOISE_SEED};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= PAT_ONES;
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= 1'b0;
         done_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (start) sel_q <= pattern_sel;
         vsync_q <= go && tg_vs;
         hsync_q <= go && tg_hs;
         valid_q <= go && tg_act;
         data_q  <= go && tg_act && pix;
         done_q  <= wrap;
         if (wrap) fcnt_q <= fcnt_q + 16'd1;
      end
   end

   assign post_img_vsync = vsync_q;
   assign post_img_hsync = hsync_q;
   assign post_img_valid = valid_q;
   assign post_img_data  = data_q;
   assign frame_done     = done_q;
   assign frame_cnt      = fcnt_q;

endmodule

// File: tb/tb_bin_video_source.sv
// Directed bench for bin_video_source on a 14x7 raster (8x4 active, cell pitch 2).
module tb_bin_video_source;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FR = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic [7:0]  noise_density = 8'd0;
   logic        post_img_vsync, post_img_hsync, post_img_valid, post_img_data, frame_done;
   logic [15:0] frame_cnt;

   int tests = 0;
   int fails = 0;

   logic cap_vs[FR], cap_hs[FR], cap_vl[FR], cap_dt[FR], cap_fd[FR];

   bin_video_source #(
      .H_SYNC(11'd2), .H_BACK(11'd2), .H_DISP(11'd8), .H_FRONT(11'd2), .H_TOTAL(11'd14),
      .V_SYNC(11'd1), .V_BACK(11'd1), .V_DISP(11'd4), .V_FRONT(11'd1), .V_TOTAL(11'd7),
      .CELL_LOG2(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
      .noise_density(noise_density),
      .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
      .post_img_valid(post_img_valid), .post_img_data(post_img_data),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_pix(input logic [1:0] sel, input int x, input int y);
      case (sel)
         2'd0:    return 1'b1;
         2'd1:    return x[1] ^ y[1];
         2'd2:    return x[1];
         default: return (x[0] == 1'b0) && (y[0] == 1'b0);
      endcase
   endfunction

   // Sample one 98-clock frame; optionally change sel or drop enable after sample k.
   task automatic capture(input int chg_k, input logic [1:0] chg_sel, input int drop_k);
      for (int k = 0; k < FR; k++) begin
         @(negedge clk);
         cap_vs[k] = post_img_vsync;
         cap_hs[k] = post_img_hsync;
         cap_vl[k] = post_img_valid;
         cap_dt[k] = post_img_data;
         cap_fd[k] = frame_done;
         if (k == chg_k) pattern_sel = chg_sel;
         if (k == drop_k) enable = 1'b0;
      end
   endtask

   function automatic logic [7:0] row(input int y);
      logic [7:0] r = '0;
      for (int x = 0; x < 8; x++) r = {r[6:0], cap_dt[(y + 2) * HT + 4 + x]};
      return r;
   endfunction

   task automatic check_frame(input string tag, input logic [1:0] sel, input int fno,
                              output int ones);
      int nv = 0, nh = 0, nvs = 0, nfd = 0, bad = 0;
      ones = 0;
      for (int k = 0; k < FR; k++) begin
         int h = k % HT, v = k / HT;
         logic act, ed;
         act = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
         ed  = act ? exp_pix(sel, h - 4, v - 2) : 1'b0;
         if ({cap_vs[k], cap_hs[k], cap_vl[k], cap_dt[k], cap_fd[k]} !==
             {v < 1, h < 2, act, ed, k == FR - 1}) bad++;
         nv  += int'(cap_vl[k]);
         nh  += int'(cap_hs[k]);
         nvs += int'(cap_vs[k]);
         nfd += int'(cap_fd[k]);
         ones += int'(cap_dt[k]);
      end
      check({tag, "_valid_cnt"}, nv, 32);
      check({tag, "_hsync_cnt"}, nh, 14);
      check({tag, "_vsync_cnt"}, nvs, 14);
      check({tag, "_done_cnt"}, nfd, 1);
      check({tag, "_done_last"}, cap_fd[FR - 1], 1);
      check({tag, "_pixel_bad"}, bad, 0);
      check({tag, "_frame_cnt"}, frame_cnt, fno);
   endtask

   initial begin
      int ones, nz;
      #2;
      check("rst_vsync", post_img_vsync, 0);
      check("rst_hsync", post_img_hsync, 0);
      check("rst_valid", post_img_valid, 0);
      check("rst_data", post_img_data, 0);
      check("rst_done", frame_done, 0);
      check("rst_fcnt", frame_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nz = 0;
      repeat (5) begin
         @(negedge clk);
         if ({post_img_vsync, post_img_hsync, post_img_valid, post_img_data, frame_done} != 0) nz++;
      end
      check("idle_quiet", nz, 0);

      // All-ones; sel changes mid-frame and must only affect the next frame.
      enable = 1'b1;
      capture(60, 2'd1, -1);
      check_frame("f1_ones", 2'd0, 1, ones);
      check("f1_ones_total", ones, 32);

      capture(60, 2'd3, -1);
      check_frame("f2_check", 2'd1, 2, ones);
      check("f2_row0", row(0), 8'b00110011);
      check("f2_row2", row(2), 8'b11001100);

      capture(60, 2'd1, -1);
      check_frame("f3_dots", 2'd3, 3, ones);
      check("f3_dots_total", ones, 8);
      check("f3_dot_2_2", cap_dt[4 * HT + 6], 1);
      check("f3_nodot_1_0", cap_dt[2 * HT + 5], 0);

      capture(50, 2'd2, -1);
      check_frame("f4_check", 2'd1, 4, ones);

      // Stripes frame; enable drops at clock 40 but the frame still completes.
      capture(-1, 2'd0, 40);
      check_frame("f5_stripe", 2'd2, 5, ones);
      for (int y = 0; y < 4; y++) check($sformatf("f5_row%0d", y), row(y), 8'b00110011);

      nz = 0;
      repeat (30) begin
         @(negedge clk);
         if ({post_img_vsync, post_img_hsync, post_img_valid, post_img_data, frame_done} != 0) nz++;
      end
      check("drain_quiet", nz, 0);
      check("drain_fcnt", frame_cnt, 5);

      enable = 1'b1;
      capture(-1, 2'd0, -1);
      check("restart_hsync", cap_hs[0], 1);
      check_frame("f6_restart", 2'd2, 6, ones);

      // Reset in the middle of an active stripe pixel.
      repeat (35) @(negedge clk);
      check("pre_rst_valid", post_img_valid, 1);
      check("pre_rst_data", post_img_data, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out",
            {post_img_vsync, post_img_hsync, post_img_valid, post_img_data, frame_done}, 0);
      check("async_rst_fcnt", frame_cnt, 0);

`ifdef BIN_SRC_NOISE_EN
      begin
         int nv = 0, n1 = 0;
         enable = 1'b0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         pattern_sel = 2'd0;
         noise_density = 8'd255;
         enable = 1'b1;
         repeat (100 * FR) begin
            @(negedge clk);
            nv += int'(post_img_valid);
            n1 += int'(post_img_data);
         end
         check("noise_valid_total", nv, 3200);
         check("noise_ones_rate", (n1 * 128 <= nv), 1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
